edge_frame_writer: RTL and testbench
====================================

Name: edge_frame_writer

Overview:
- Downstream consumer of the edge-detector output stream: the 12-bit pixel plus valid stream that the edge filter produces (0xFFF = edge, 0x000 = background).
- Thresholds each pixel to 1 bit and packs 8 consecutive pixels into a byte.
- Writes whole frames, byte by byte, into the frame-buffer RAM write port that the VGA display side reads.
- Frame capture is armed per frame by a start pulse; the block reports completion and aborted frames.

Parameters:
- H_ACTIVE, 640, pixels per line; must be a multiple of 8.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 16, width of the byte address; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE/8.
- THRESH, 12'h800, a pixel is an edge (bit = 1) when datain >= THRESH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse; arms (or re-arms) capture of one frame.
- datain  in  12  pixel value from the edge filter.
- datain_en  in  1  pixel valid; one pixel is accepted per cycle while high.
- wr_en  out  1  frame-buffer write strobe, single-cycle.
- wr_addr  out  ADDR_W  byte address in the frame buffer.
- wr_data  out  8  packed pixels; bit k = pixel (8*n + k) of the frame, LSB first.
- busy  out  1  high while capturing (state FILL).
- frame_done  out  1  single-cycle pulse when a full frame has been written.
- frame_abort  out  1  single-cycle pulse when a capture in progress is restarted.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Outputs: wr_en, wr_addr, wr_data, busy, frame_done and frame_abort all go to 0.
  - Internal state: FSM = IDLE; col, row, byte counter and shift register all cleared.
- FSM states and transitions:
  - IDLE -> FILL on frame_start.
  - FILL -> DONE after the last pixel (row = V_ACTIVE-1, col = H_ACTIVE-1) is accepted.
  - DONE -> IDLE unconditionally after 1 cycle; DONE -> FILL instead if frame_start is high in that cycle.
- IDLE:
  - datain_en is ignored; no writes are issued.
  - A pixel presented in the same cycle as frame_start is dropped. The first accepted pixel is the first datain_en in FILL.
- FILL, per accepted pixel:
  - bit = (datain >= THRESH), unsigned compare.
  - The bit is stored into shift register position col[2:0].
  - col increments; when col = H_ACTIVE-1 it wraps to 0 and row increments.
- Write timing:
  - When the accepted pixel has col[2:0] = 7, the next cycle drives wr_en = 1, wr_data = the completed byte, and wr_addr = the byte counter.
  - The byte counter then increments. Write latency is 1 cycle after the 8th pixel.
  - wr_addr = row*(H_ACTIVE/8) + col/8, implemented as a running counter; it never wraps within a frame.
  - wr_data and wr_addr hold their last values when wr_en = 0.
- Flow control:
  - Gaps in datain_en are allowed anywhere, including mid-byte and mid-line; counters hold during gaps.
  - There is no backpressure: the RAM port accepts every write.
- Frame completion:
  - The final byte write occurs in the DONE cycle.
  - frame_done pulses the cycle after that write, i.e. 2 cycles after the last pixel is accepted.
  - busy drops in the DONE cycle.
- datain_en during DONE: the pixel is dropped.
- frame_start during FILL (restart):
  - Counters and shift register are cleared; any partial byte is discarded with no write.
  - frame_abort pulses the next cycle; the FSM stays in FILL.
  - If datain_en is high in the same cycle, that pixel is dropped.
- frame_start in the same cycle as the pixel that completes a byte: restart wins and the write is suppressed.
- Reset asserted mid-frame: all state is cleared immediately; no further writes and no frame_done.

Test Plan:
(All scenarios use H_ACTIVE=16, V_ACTIVE=2, THRESH=12'h800.)
- Basic frame:
  - Stimulus: frame_start, then 32 consecutive pixels alternating 0xFFF, 0x000.
  - Response: 4 writes at addr 0,1,2,3, each wr_data = 8'h55; frame_done 2 cycles after the last pixel; busy low after.
- Threshold boundary:
  - Stimulus: the first byte's pixels are 0x7FF, 0x800, 0xFFF, 0x000, 0x800, 0x7FF, 0x000, 0xFFF.
  - Response: wr_data = 8'b1001_0110 at addr 0.
- Gapped input:
  - Stimulus: the basic frame with datain_en low for 3 cycles after every 5th pixel.
  - Response: same 4 writes/data as the basic frame; each write occurs 1 cycle after its 8th pixel.
- Idle and done drops:
  - Stimulus: 10 valid pixels before frame_start; 1 pixel coinciding with frame_start; 1 pixel during DONE.
  - Response: none of these pixels is written; the frame still yields exactly 4 writes.
- Restart mid-frame:
  - Stimulus: frame_start after 11 pixels (1 write done at addr 0), then a full 32-pixel frame.
  - Response: frame_abort pulse; partial byte discarded; new writes start at addr 0; 4 writes; 1 frame_done.
- Async reset mid-frame:
  - Stimulus: rst low for 2 cycles after 20 pixels.
  - Response: all outputs 0 immediately; no wr_en until the next frame_start; a subsequent frame writes addr 0..3.

Source files
------------

// File: rtl/edge_frame_writer.sv
// Thresholds the edge-filter pixel stream to 1 bit per pixel, packs 8 pixels
// per byte (LSB first) and writes whole frames into the frame-buffer RAM port.
module edge_frame_writer #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          ADDR_W   = 16,
  parameter logic [11:0] THRESH   = 12'h800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [11:0]       datain,
  input  logic              datain_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   byte_q, byte_d;
  logic [7:0]          sr_q, sr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                pix_bit;
  logic                clear;

  assign pix_bit = (datain >= THRESH);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    byte_d    = byte_q;
    sr_d      = sr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = (state_q == DONE);
    abort_d   = 1'b0;
    clear     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FILL;
          clear   = 1'b1;
        end
      end
      FILL: begin
        // A restart beats both the pixel and any byte it would have completed.
        if (frame_start) begin
          clear   = 1'b1;
          abort_d = 1'b1;
        end else if (datain_en) begin
          sr_d[col_q[2:0]] = pix_bit;
          if (col_q[2:0] == 3'd7) begin
            wr_en_d   = 1'b1;
            wr_data_d = sr_d;
            wr_addr_d = byte_q;
            byte_d    = byte_q + 1'b1;
          end
          if (col_q == COL_W'(H_ACTIVE - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(V_ACTIVE - 1)) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = frame_start ? FILL : IDLE;
        clear   = frame_start;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      byte_d = '0;
      sr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      byte_q    <= '0;
      sr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      byte_q    <= byte_d;
      sr_q      <= sr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == FILL);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// Directed bench for edge_frame_writer on a 16x2 frame (4 bytes per frame).
module tb_edge_frame_writer;

  localparam int H = 16;
  localparam int V = 2;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [11:0]   datain = '0;
  logic          datain_en = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_abort;

  int checks = 0;
  int failures = 0;
  int nw = 0;
  int ndone = 0;
  int nabort = 0;

  logic [11:0] pix [32];
  logic [7:0]  eb  [4];

  edge_frame_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .THRESH(12'h800)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .datain(datain),
    .datain_en(datain_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) nw++;
    if (frame_done === 1'b1) ndone++;
    if (frame_abort === 1'b1) nabort++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic en, input logic [11:0] d);
    frame_start = fs;
    datain_en   = en;
    datain      = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_alt();
    for (int k = 0; k < 32; k++) pix[k] = (k % 2 == 0) ? 12'hFFF : 12'h000;
    for (int b = 0; b < 4; b++) eb[b] = 8'h55;
  endtask

  // Streams pix[] as one frame (start already issued); a pixel is also
  // offered in the DONE cycle and must be dropped.
  task automatic run_frame(input bit gap);
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b1, pix[k]);
      tick();
      if (k % 8 == 7) begin
        chk("wr_en_byte", {31'd0, wr_en}, 32'd1);
        chk("wr_addr", {16'd0, wr_addr}, k / 8);
        chk("wr_data", {24'd0, wr_data}, {24'd0, eb[k / 8]});
      end else begin
        chk("wr_en_mid", {31'd0, wr_en}, 32'd0);
      end
      if (gap && (k % 5 == 4) && k != 31) begin
        drive(1'b0, 1'b0, 12'h000);
        repeat (3) tick();
      end
    end
    chk("busy_done_state", {31'd0, busy}, 32'd0);
    chk("frame_done_early", {31'd0, frame_done}, 32'd0);
    drive(1'b0, 1'b1, 12'hFFF);
    tick();
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("wr_en_after_done", {31'd0, wr_en}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 12'h000);
    tick();
    chk("frame_done_single", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic start_frame(input logic en, input logic [11:0] d);
    drive(1'b1, en, d);
    tick();
    drive(1'b0, 1'b0, 12'h000);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    rst = 1'b1;
    tick();

    // Idle drops, then a pixel coinciding with frame_start, then basic frame
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 12'hFFF);
      tick();
      chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    load_alt();
    start_frame(1'b1, 12'hFFF);
    run_frame(1'b0);
    chk("basic_writes", nw, 32'd4);
    chk("basic_dones", ndone, 32'd1);

    // Threshold boundary in the first byte
    pix[0] = 12'h7FF; pix[1] = 12'h800; pix[2] = 12'hFFF; pix[3] = 12'h000;
    pix[4] = 12'h800; pix[5] = 12'h7FF; pix[6] = 12'h000; pix[7] = 12'hFFF;
    eb[0] = 8'b1001_0110;
    start_frame(1'b0, 12'h000);
    run_frame(1'b0);
    chk("thresh_writes", nw, 32'd8);

    // Gapped input
    load_alt();
    start_frame(1'b0, 12'h000);
    run_frame(1'b1);
    chk("gap_writes", nw, 32'd12);
    chk("gap_dones", ndone, 32'd3);

    // Restart after 11 pixels
    start_frame(1'b0, 12'h000);
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, 1'b1, pix[k]);
      tick();
      if (k == 7) chk("pre_restart_addr", {16'd0, wr_addr}, 32'd0);
    end
    drive(1'b1, 1'b1, 12'hFFF);
    tick();
    chk("restart_abort", {31'd0, frame_abort}, 32'd1);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    run_frame(1'b0);
    chk("restart_writes", nw, 32'd17);
    chk("restart_aborts", nabort, 32'd1);
    chk("restart_dones", ndone, 32'd4);

    // Restart in the same cycle as a byte-completing pixel
    start_frame(1'b0, 12'h000);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, pix[k]);
      tick();
    end
    drive(1'b1, 1'b1, pix[7]);
    tick();
    chk("restart_byte_wr_en", {31'd0, wr_en}, 32'd0);
    chk("restart_byte_abort", {31'd0, frame_abort}, 32'd1);
    run_frame(1'b0);
    chk("restart_byte_writes", nw, 32'd21);

    // Asynchronous reset mid-frame
    start_frame(1'b0, 12'h000);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, pix[k]);
      tick();
    end
    drive(1'b0, 1'b1, pix[20]);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("arst_wr_data", {24'd0, wr_data}, 32'd0);
    repeat (2) tick();
    chk("arst_hold_wr_en", {31'd0, wr_en}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b1, 12'hFFF);
      tick();
      chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
    end
    chk("arst_writes", nw, 32'd23);
    chk("arst_dones", ndone, 32'd5);
    start_frame(1'b0, 12'h000);
    run_frame(1'b0);
    chk("final_writes", nw, 32'd27);
    chk("final_dones", ndone, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
